// File: rtl/flash_boot_loader.sv
// Boot-time copier: reads a kernel image from x16 NOR flash and writes it as 32-bit words into SRAM.
// Optional build macro BOOT_CHECKSUM_EN adds checksum_o, an XOR of every word written.
module flash_boot_loader #(
   parameter int unsigned WORD_COUNT = 4210,
   parameter logic [31:0] SRAM_BASE  = 32'h8000_0000,
   parameter int unsigned FLASH_WAIT = 8,
   parameter int unsigned RP_CYCLES  = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic [21:0] flash_addr,
   input  logic [15:0] flash_data_i,
   output logic        flash_ce_n,
   output logic        flash_oe_n,
   output logic        flash_we_n,
   output logic        flash_rp_n,
   output logic        flash_byte_n,
   output logic        flash_vpen,
   output logic        mem_ce_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_sel_o,
   output logic [31:0] mem_data_o,
`ifdef BOOT_CHECKSUM_EN
   output logic [31:0] checksum_o,
`endif
   output logic        busy,
   output logic        load_complete
);

   // state       | meaning
   // RST_FLASH   | hold flash in reset/power-down, then release rp_n
   // RD_LO       | read even halfword of the current word
   // GAP         | one cycle with oe_n high for bus turnaround
   // RD_HI       | read odd halfword of the current word
   // WR          | single-cycle write of {hi,lo} into SRAM
   // WR_IDLE     | write strobe dropped, advance word counter
   // DONE        | copy finished, wait for rst
   localparam logic [2:0] S_RST_FLASH = 3'd0;
   localparam logic [2:0] S_RD_LO     = 3'd1;
   localparam logic [2:0] S_GAP       = 3'd2;
   localparam logic [2:0] S_RD_HI     = 3'd3;
   localparam logic [2:0] S_WR        = 3'd4;
   localparam logic [2:0] S_WR_IDLE   = 3'd5;
   localparam logic [2:0] S_DONE      = 3'd6;

   localparam logic [15:0] WAIT_LAST = 16'(FLASH_WAIT - 1);
   localparam logic [15:0] RP_LAST   = 16'(RP_CYCLES);
   localparam logic [16:0] WC_END    = 17'(WORD_COUNT);
   localparam bit          WC_ZERO   = (WORD_COUNT == 0);

   logic [2:0]  state;
   logic [15:0] word_cnt;
   logic [15:0] wait_cnt;
   logic [15:0] lo;
   logic [16:0] next_cnt;

   assign next_cnt     = {1'b0, word_cnt} + 17'd1;
   assign flash_we_n   = 1'b1;
   assign flash_byte_n = 1'b1;
   assign flash_vpen   = 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_RST_FLASH;
         word_cnt      <= '0;
         wait_cnt      <= '0;
         lo            <= '0;
         flash_addr    <= '0;
         flash_ce_n    <= 1'b1;
         flash_oe_n    <= 1'b1;
         flash_rp_n    <= 1'b0;
         mem_ce_o      <= 1'b0;
         mem_we_o      <= 1'b0;
         mem_addr_o    <= '0;
         mem_sel_o     <= '0;
         mem_data_o    <= '0;
         busy          <= 1'b1;
         load_complete <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         checksum_o    <= '0;
`endif
      end else begin
         case (state)
            S_RST_FLASH: begin
               if (wait_cnt == RP_LAST) begin
                  wait_cnt   <= '0;
                  flash_rp_n <= 1'b1;
                  if (WC_ZERO) begin
                     state         <= S_DONE;
                     busy          <= 1'b0;
                     load_complete <= 1'b1;
                  end else begin
                     state      <= S_RD_LO;
                     flash_addr <= {5'd0, word_cnt, 1'b0};
                     flash_ce_n <= 1'b0;
                     flash_oe_n <= 1'b0;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            S_RD_LO: begin
               // data is only trusted on the last wait cycle
               if (wait_cnt == WAIT_LAST) begin
                  wait_cnt   <= '0;
                  lo         <= flash_data_i;
                  flash_oe_n <= 1'b1;
                  state      <= S_GAP;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            S_GAP: begin
               flash_addr <= {5'd0, word_cnt, 1'b1};
               flash_oe_n <= 1'b0;
               state      <= S_RD_HI;
            end
            S_RD_HI: begin
               if (wait_cnt == WAIT_LAST) begin
                  wait_cnt   <= '0;
                  flash_oe_n <= 1'b1;
                  mem_ce_o   <= 1'b1;
                  mem_we_o   <= 1'b1;
                  mem_sel_o  <= 4'b1111;
                  mem_addr_o <= SRAM_BASE + {14'd0, word_cnt, 2'b00};
                  mem_data_o <= {flash_data_i, lo};
`ifdef BOOT_CHECKSUM_EN
                  checksum_o <= checksum_o ^ {flash_data_i, lo};
`endif
                  state      <= S_WR;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            S_WR: begin
               mem_ce_o   <= 1'b0;
               mem_we_o   <= 1'b0;
               mem_sel_o  <= '0;
               mem_addr_o <= '0;
               mem_data_o <= '0;
               state      <= S_WR_IDLE;
            end
            S_WR_IDLE: begin
               word_cnt <= next_cnt[15:0];
               if (next_cnt == WC_END) begin
                  state         <= S_DONE;
                  flash_ce_n    <= 1'b1;
                  flash_oe_n    <= 1'b1;
                  busy          <= 1'b0;
                  load_complete <= 1'b1;
               end else begin
                  state      <= S_RD_LO;
                  flash_addr <= {5'd0, next_cnt[15:0], 1'b0};
                  flash_oe_n <= 1'b0;
               end
            end
            S_DONE: begin
               state <= S_DONE;
            end
            default: begin
               state <= S_RST_FLASH;
            end
         endcase
      end
   end

endmodule
